modulo_varre_linha: RTL and testbench
=====================================

MODULO_VARRE_LINHA -- requirements
Module: modulo_varre_linha

Interface
REQ-001 SHALL have parameter N_ROWS, default 7: number of matrix rows scanned, range 2..16.
REQ-002 SHALL have parameter DWELL, default 1000: clock cycles each row is driven, minimum 1.
REQ-003 SHALL have parameter BLANK, default 2: all-rows-off cycles between rows, 0 allowed.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 = asserted row line is 0, 0 = asserted row line is 1.
REQ-005 SHALL have derived width IDX_W = max(1, clog2(N_ROWS)).
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port en, input, 1 bit: scan enable.
REQ-009 SHALL have port hold, input, 1 bit: freeze scan on hold_row.
REQ-010 SHALL have port hold_row, input, IDX_W bits: row index driven while hold is high.
REQ-011 SHALL have port row_sel, output, N_ROWS bits: one-hot row drive, polarity per ACTIVE_LOW.
REQ-012 SHALL have port row_idx, output, IDX_W bits: binary index of the current row.
REQ-013 SHALL have port row_strobe, output, 1 bit: one-cycle pulse on the first SHOW cycle of each row.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse when row N_ROWS-1 completes its dwell.

Function
REQ-015 SHALL implement FSM states IDLE, SHOW, BLANK.
REQ-016 IDLE: row_sel all de-asserted; on en=1, go to SHOW with dwell counter 0 and row_strobe=1 on the first SHOW cycle.
REQ-017 SHOW: exactly one row_sel bit asserted (bit row_idx); count DWELL cycles, then go to BLANK (or straight to the next SHOW row if BLANK=0).
REQ-018 BLANK: all rows de-asserted for exactly BLANK cycles; row_idx already advanced; then SHOW.
REQ-019 Advance rule: row_idx = row_idx+1, wrapping from N_ROWS-1 to 0; frame_done pulses on the last SHOW cycle of row N_ROWS-1.
REQ-020 All outputs SHALL be registered; row_sel SHALL change only at state/row transitions, never glitch combinationally.
REQ-021 hold=1 in SHOW SHALL drive hold_row continuously; the dwell counter does not advance and no row_strobe or frame_done pulses occur.
REQ-022 hold_row >= N_ROWS SHALL be clamped to N_ROWS-1.
REQ-023 A hold_row change while held SHALL take effect on the next cycle, without blanking.
REQ-024 hold falling SHALL resume normal scan at the held row with the dwell counter at 0, plus one row_strobe.
REQ-025 en=0 in any state SHALL go to IDLE on the next cycle; row_idx keeps its value; re-enable resumes at that row with a fresh dwell.
REQ-026 en=0 together with hold=1: en SHALL win.
REQ-027 Dwell counter width SHALL be clog2(DWELL+1); terminal compare is at DWELL-1; no overflow is permitted.

Reset
REQ-028 rst=1 at any clock edge SHALL force IDLE, counters 0, row_idx 0, row_strobe 0, frame_done 0, and row_sel all de-asserted (all 1s if ACTIVE_LOW, else all 0s).
REQ-029 Reset mid-SHOW or mid-BLANK SHALL take effect on that edge with no partial pulse.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE/SHOW/BLANK) and the clog2 helper, for reuse by the column driver.
REQ-031 One sub-module SHALL exist: modulo_decod_linha (index to one-hot with polarity parameter), registered at its output by the parent.

Verification
REQ-032 N_ROWS=5, DWELL=4, BLANK=1, ACTIVE_LOW=0, en=1 from reset -> row_sel 00001 for 4 cycles, 00000 for 1, 00010 for 4, ...; frame_done every 25 cycles; 5 row_strobes per frame.
REQ-033 Same config, hold=1 with hold_row=2 during row 0 -> row_sel=00100 next cycle and stays; no strobes; hold released -> 00100 for 4 more cycles, then blank, then 01000.
REQ-034 hold_row=7 with N_ROWS=5 -> row_sel=10000 and row_idx=4.
REQ-035 en dropped mid-row 3 -> all rows off next cycle; en re-raised -> row 3 shown for a full 4 cycles, with a strobe.
REQ-036 rst pulsed during BLANK, ACTIVE_LOW=1 -> row_sel=11111, row_idx=0, no frame_done; restart at row 0.
REQ-037 BLANK=0, DWELL=1 -> the row advances every cycle, one-hot is never empty, and frame_done fires every 5 cycles.

Source files
------------

// File: rtl/modulo_varre_linha_pkg.sv
// Shared definitions for the matrix row scanner and the column driver.
package modulo_varre_linha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Keeps derived widths at a minimum of one bit.
  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/modulo_decod_linha.sv
// Row index to one-hot decoder with selectable output polarity.
module modulo_decod_linha #(
  parameter int N_ROWS     = 7,
  parameter int IDX_W      = 3,
  parameter int ACTIVE_LOW = 1
)(
  input  logic [IDX_W-1:0]  idx,
  input  logic              on,
  output logic [N_ROWS-1:0] sel
);

  // One-hot of idx when on, otherwise all rows off; polarity applied last.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_ROWS; i++) sel[i] = on && (idx == IDX_W'(i));
    if (ACTIVE_LOW != 0) sel = ~sel;
  end

endmodule

// File: rtl/modulo_varre_linha.sv
// Matrix row scanner: each row is shown for DWELL cycles, separated by
// BLANK all-off cycles, with hold/override and enable control.
module modulo_varre_linha
  import modulo_varre_linha_pkg::*;
#(
  parameter int N_ROWS     = 7,
  parameter int DWELL      = 1000,
  parameter int BLANK      = 2,
  parameter int ACTIVE_LOW = 1,
  localparam int IDX_W     = max1(clog2(N_ROWS))
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              hold,
  input  logic [IDX_W-1:0]  hold_row,
  output logic [N_ROWS-1:0] row_sel,
  output logic [IDX_W-1:0]  row_idx,
  output logic              row_strobe,
  output logic              frame_done
);

  localparam int CNT_W = max1(clog2(DWELL + 1));
  localparam int BLK_W = max1(clog2(BLANK + 1));
  localparam logic [IDX_W-1:0]  LAST_ROW = IDX_W'(N_ROWS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DWELL - 1);
  localparam logic [BLK_W-1:0]  LAST_BLK = BLK_W'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [N_ROWS-1:0] ROWS_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   row_q, row_d, hold_clamped, row_next;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic               held_q, held_d;
  logic               row_strobe_q, row_strobe_d;
  logic               frame_done_q, frame_done_d;
  logic [N_ROWS-1:0]  row_sel_q, row_sel_d;
  logic               show_d;

  assign hold_clamped = (32'(hold_row) >= 32'(N_ROWS)) ? LAST_ROW : hold_row;
  assign row_next     = (row_q == LAST_ROW) ? '0 : row_q + IDX_W'(1);

  // Next-state: the _q registers describe the cycle currently on the outputs.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    blk_d        = blk_q;
    held_d       = 1'b0;
    row_strobe_d = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      blk_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d      = ST_SHOW;
          cnt_d        = '0;
          row_strobe_d = 1'b1;
        end
        ST_SHOW: begin
          if (hold) begin
            row_d  = hold_clamped;
            cnt_d  = '0;
            held_d = 1'b1;
          end else if (held_q) begin
            // First free cycle after a hold restarts the held row.
            cnt_d        = '0;
            row_strobe_d = 1'b1;
          end else if (cnt_q == LAST_CNT) begin
            row_d = row_next;
            cnt_d = '0;
            if (BLANK == 0) row_strobe_d = 1'b1;
            else begin
              state_d = ST_BLANK;
              blk_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_BLANK: begin
          if (blk_q == LAST_BLK) begin
            state_d      = ST_SHOW;
            cnt_d        = '0;
            blk_d        = '0;
            row_strobe_d = 1'b1;
          end else begin
            blk_d = blk_q + BLK_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign show_d       = (state_d == ST_SHOW);
  assign frame_done_d = show_d && !held_d && (row_d == LAST_ROW) && (cnt_d == LAST_CNT);

  modulo_decod_linha #(
    .N_ROWS     (N_ROWS),
    .IDX_W      (IDX_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_decod (
    .idx (row_d),
    .on  (show_d),
    .sel (row_sel_d)
  );

  // State and output registers; outputs are decoded from next state so
  // they line up with the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      cnt_q        <= '0;
      blk_q        <= '0;
      held_q       <= 1'b0;
      row_sel_q    <= ROWS_OFF;
      row_strobe_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      blk_q        <= blk_d;
      held_q       <= held_d;
      row_sel_q    <= row_sel_d;
      row_strobe_q <= row_strobe_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row_sel    = row_sel_q;
  assign row_idx    = row_q;
  assign row_strobe = row_strobe_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_modulo_varre_linha.sv
// Directed bench for the row scanner: three configurations on one clock.
module tb_modulo_varre_linha;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_b;
  logic en_a, hold_a, en_b, hold_b, en_c, hold_c;
  logic [2:0] hrow_a, hrow_b, hrow_c;
  logic [4:0] sel_a, sel_b, sel_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic stb_a, frm_a, stb_b, frm_b, stb_c, frm_c;

  int total = 0, passed = 0, failed = 0;
  int n_stb, n_frm;

  modulo_varre_linha #(.N_ROWS(5), .DWELL(4), .BLANK(1), .ACTIVE_LOW(0)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .hold(hold_a), .hold_row(hrow_a),
    .row_sel(sel_a), .row_idx(idx_a), .row_strobe(stb_a), .frame_done(frm_a));

  modulo_varre_linha #(.N_ROWS(5), .DWELL(4), .BLANK(1), .ACTIVE_LOW(1)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .hold(hold_b), .hold_row(hrow_b),
    .row_sel(sel_b), .row_idx(idx_b), .row_strobe(stb_b), .frame_done(frm_b));

  modulo_varre_linha #(.N_ROWS(5), .DWELL(1), .BLANK(0), .ACTIVE_LOW(0)) u_c (
    .clk(clk), .rst(rst), .en(en_c), .hold(hold_c), .hold_row(hrow_c),
    .row_sel(sel_c), .row_idx(idx_c), .row_strobe(stb_c), .frame_done(frm_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    en_a = 1'b0; hold_a = 1'b0; hrow_a = 3'd0;
    en_b = 1'b0; hold_b = 1'b0; hrow_b = 3'd0;
    en_c = 1'b0; hold_c = 1'b0; hrow_c = 3'd0;
    step(); step();
    chk("rst_a_sel", 32'(sel_a), 32'h00);
    chk("rst_a_idx", 32'(idx_a), 32'd0);
    chk("rst_a_stb", 32'(stb_a), 32'd0);
    chk("rst_a_frm", 32'(frm_a), 32'd0);
    chk("rst_b_sel", 32'(sel_b), 32'h1f);
    chk("rst_c_sel", 32'(sel_c), 32'h00);
    rst = 1'b0; rst_b = 1'b0;

    // Free-running scan, two frames of 25 cycles.
    en_a = 1'b1;
    n_stb = 0; n_frm = 0;
    for (int k = 0; k < 50; k++) begin
      int p, r, w;
      step();
      p = k % 25; r = p / 5; w = p % 5;
      if (stb_a) n_stb++;
      if (frm_a) n_frm++;
      if (w < 4) begin
        chk($sformatf("scan_sel_k%0d", k), 32'(sel_a), 32'(1 << r));
        chk($sformatf("scan_idx_k%0d", k), 32'(idx_a), 32'(r));
        chk($sformatf("scan_stb_k%0d", k), 32'(stb_a), 32'(w == 0));
        chk($sformatf("scan_frm_k%0d", k), 32'(frm_a), 32'(r == 4 && w == 3));
      end else begin
        chk($sformatf("blank_sel_k%0d", k), 32'(sel_a), 32'h00);
        chk($sformatf("blank_idx_k%0d", k), 32'(idx_a), 32'((r + 1) % 5));
        chk($sformatf("blank_frm_k%0d", k), 32'(frm_a), 32'd0);
      end
    end
    chk("scan_strobes", 32'(n_stb), 32'd10);
    chk("scan_frames", 32'(n_frm), 32'd2);

    // Hold on row 2 while row 0 is showing.
    step();
    chk("row0_again_sel", 32'(sel_a), 32'h01);
    chk("row0_again_stb", 32'(stb_a), 32'd1);
    hold_a = 1'b1; hrow_a = 3'd2;
    step();
    chk("hold_sel", 32'(sel_a), 32'h04);
    chk("hold_idx", 32'(idx_a), 32'd2);
    chk("hold_stb", 32'(stb_a), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("held_sel_%0d", i), 32'(sel_a), 32'h04);
      chk($sformatf("held_stb_%0d", i), 32'(stb_a), 32'd0);
      chk($sformatf("held_frm_%0d", i), 32'(frm_a), 32'd0);
    end
    hold_a = 1'b0;
    step();
    chk("release_sel", 32'(sel_a), 32'h04);
    chk("release_stb", 32'(stb_a), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("release_dwell_sel_%0d", i), 32'(sel_a), 32'h04);
      chk($sformatf("release_dwell_stb_%0d", i), 32'(stb_a), 32'd0);
    end
    step();
    chk("release_blank_sel", 32'(sel_a), 32'h00);
    chk("release_blank_idx", 32'(idx_a), 32'd3);
    step();
    chk("row3_sel", 32'(sel_a), 32'h08);
    chk("row3_stb", 32'(stb_a), 32'd1);

    // Out-of-range hold row clamps to the last row; hold_row change has no blank.
    hold_a = 1'b1; hrow_a = 3'd7;
    step();
    chk("clamp_sel", 32'(sel_a), 32'h10);
    chk("clamp_idx", 32'(idx_a), 32'd4);
    hrow_a = 3'd1;
    step();
    chk("hold_move_sel", 32'(sel_a), 32'h02);
    chk("hold_move_idx", 32'(idx_a), 32'd1);
    hold_a = 1'b0;
    step();
    chk("release1_sel", 32'(sel_a), 32'h02);
    chk("release1_stb", 32'(stb_a), 32'd1);

    // Drop enable in the middle of row 3, then re-enable.
    for (int i = 0; i < 10; i++) step();
    chk("reach_row3_sel", 32'(sel_a), 32'h08);
    chk("reach_row3_stb", 32'(stb_a), 32'd1);
    step();
    en_a = 1'b0;
    step();
    chk("en_off_sel", 32'(sel_a), 32'h00);
    chk("en_off_idx", 32'(idx_a), 32'd3);
    chk("en_off_stb", 32'(stb_a), 32'd0);
    step();
    chk("en_off2_sel", 32'(sel_a), 32'h00);
    en_a = 1'b1;
    step();
    chk("reen_sel", 32'(sel_a), 32'h08);
    chk("reen_idx", 32'(idx_a), 32'd3);
    chk("reen_stb", 32'(stb_a), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reen_dwell_sel_%0d", i), 32'(sel_a), 32'h08);
      chk($sformatf("reen_dwell_stb_%0d", i), 32'(stb_a), 32'd0);
    end
    step();
    chk("reen_blank_sel", 32'(sel_a), 32'h00);
    chk("reen_blank_idx", 32'(idx_a), 32'd4);

    // Active-low instance: reset pulsed during the blank after row 0.
    en_b = 1'b1;
    step();
    chk("b_row0_sel", 32'(sel_b), 32'h1e);
    chk("b_row0_stb", 32'(stb_b), 32'd1);
    step(); step(); step();
    chk("b_row0_end_sel", 32'(sel_b), 32'h1e);
    step();
    chk("b_blank_sel", 32'(sel_b), 32'h1f);
    chk("b_blank_idx", 32'(idx_b), 32'd1);
    rst_b = 1'b1;
    step();
    chk("b_rst_sel", 32'(sel_b), 32'h1f);
    chk("b_rst_idx", 32'(idx_b), 32'd0);
    chk("b_rst_stb", 32'(stb_b), 32'd0);
    chk("b_rst_frm", 32'(frm_b), 32'd0);
    rst_b = 1'b0;
    step();
    chk("b_restart_sel", 32'(sel_b), 32'h1e);
    chk("b_restart_idx", 32'(idx_b), 32'd0);
    chk("b_restart_stb", 32'(stb_b), 32'd1);

    // BLANK=0, DWELL=1: a new row every cycle.
    en_c = 1'b1;
    n_frm = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (frm_c) n_frm++;
      chk($sformatf("fast_sel_k%0d", k), 32'(sel_c), 32'(1 << (k % 5)));
      chk($sformatf("fast_nonempty_k%0d", k), 32'(sel_c != 5'd0), 32'd1);
      chk($sformatf("fast_stb_k%0d", k), 32'(stb_c), 32'd1);
      chk($sformatf("fast_frm_k%0d", k), 32'(frm_c), 32'(k % 5 == 4));
    end
    chk("fast_frames", 32'(n_frm), 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
